persiana_multicanal: RTL and testbench

Multi-channel automatic blind controller: the parametrised successor of the single-blind FSM. It drives N_CH independent blinds, each with up/down motor outputs and three end/mid position sensors. Each channel has per-channel commands, a shared light sensor for automatic mode, reversal dead-time, motion timeout and a fault state. It sits between the user switch/command decoder and the motor driver pins, and runs from one system clock with an internal programmable tick prescaler.

---
 rtl/persiana_pkg.sv | 33 +++
 rtl/persiana_canal.sv | 141 ++++++++++++++
 rtl/persiana_multicanal.sv | 69 ++++++
 tb/tb_persiana_multicanal.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/persiana_pkg.sv
// Shared types for the multi-channel blind controller: command codes, channel
// FSM states, position tracker values and motion targets.
package persiana_pkg;

  localparam logic [2:0] MODE_STOP  = 3'b000;
  localparam logic [2:0] MODE_CLOSE = 3'b001;
  localparam logic [2:0] MODE_MID   = 3'b010;
  localparam logic [2:0] MODE_OPEN  = 3'b011;
  localparam logic [2:0] MODE_AUTO  = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_UP    = 3'd1,
    ST_DOWN  = 3'd2,
    ST_DEAD  = 3'd3,
    ST_FAULT = 3'd4
  } estado_t;

  typedef enum logic [1:0] {POS_UNK, POS_LOW, POS_MID, POS_HIGH} pos_t;

  typedef enum logic [1:0] {TGT_NONE, TGT_BOT, TGT_MID, TGT_TOP} tgt_t;

  // Ambient light to target in automatic mode; 11 means hold still.
  function automatic tgt_t light_target(input logic [1:0] light);
    case (light)
      2'b00:   return TGT_TOP;
      2'b01:   return TGT_MID;
      2'b10:   return TGT_BOT;
      default: return TGT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/persiana_canal.sv
// One blind channel: command register, position tracker and the motor FSM.
// The FSM and tracker only advance on prescaler ticks; commands land on any clk.
module persiana_canal
  import persiana_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 16,
  parameter int DEAD_TICKS    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       cmd_wr,
  input  logic [2:0] cmd_mode,
  input  logic [1:0] light,
  input  logic       s_inf,
  input  logic       s_med,
  input  logic       s_sup,
  output logic       subir,
  output logic       bajar,
  output logic       fault,
  output estado_t    estado
);

  localparam int MW = $clog2(TIMEOUT_TICKS + 1);
  localparam int DW = $clog2(DEAD_TICKS + 1);

  estado_t         state_q, state_d;
  tgt_t            fix_q, tgt;
  logic            auto_q, stop_pend;
  pos_t            pos_q;
  logic [MW-1:0]   mov_cnt, mov_d;
  logic [DW-1:0]   dead_cnt, dead_d;
  logic            at_tgt, want_up, dir_rev;

  // While faulted only a stop may rewrite the command; it is remembered until
  // the next tick so the FSM can leave FAULT there.
  always_ff @(posedge clk) begin
    if (reset) begin
      fix_q     <= TGT_NONE;
      auto_q    <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      if (cmd_wr && (state_q != ST_FAULT || cmd_mode == MODE_STOP)) begin
        auto_q <= 1'b0;
        case (cmd_mode)
          MODE_CLOSE: fix_q <= TGT_BOT;
          MODE_MID:   fix_q <= TGT_MID;
          MODE_OPEN:  fix_q <= TGT_TOP;
          MODE_AUTO:  auto_q <= 1'b1;
          default:    fix_q <= TGT_NONE;
        endcase
      end
      if (cmd_wr && cmd_mode == MODE_STOP) stop_pend <= 1'b1;
      else if (tick)                       stop_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q <= POS_UNK;
    end else if (tick) begin
      if (s_inf)      pos_q <= POS_LOW;
      else if (s_med) pos_q <= POS_MID;
      else if (s_sup) pos_q <= POS_HIGH;
    end
  end

  always_comb begin
    tgt = auto_q ? light_target(light) : fix_q;
    case (tgt)
      TGT_BOT: at_tgt = s_inf;
      TGT_MID: at_tgt = s_med;
      TGT_TOP: at_tgt = s_sup;
      default: at_tgt = 1'b0;
    endcase
    want_up = (tgt == TGT_TOP) || (tgt == TGT_MID && pos_q == POS_LOW);
    dir_rev = (state_q == ST_UP && !want_up) || (state_q == ST_DOWN && want_up);
  end

  always_comb begin
    state_d = state_q;
    mov_d   = mov_cnt;
    dead_d  = dead_cnt;
    if (tick) begin
      if (s_inf && s_sup) begin
        state_d = ST_FAULT;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (tgt != TGT_NONE && !at_tgt) begin
              state_d = want_up ? ST_UP : ST_DOWN;
              mov_d   = '0;
            end
          end
          ST_UP, ST_DOWN: begin
            mov_d = mov_cnt + MW'(1);
            if (at_tgt || tgt == TGT_NONE) begin
              state_d = ST_IDLE;
            end else if (dir_rev || (state_q == ST_UP && s_sup)) begin
              // Reversal or overshoot past the top: idle both motors first.
              state_d = ST_DEAD;
              dead_d  = '0;
            end else if (mov_cnt == MW'(TIMEOUT_TICKS - 1)) begin
              state_d = ST_FAULT;
            end
          end
          ST_DEAD: begin
            if (tgt == TGT_NONE) begin
              state_d = ST_IDLE;
            end else if (dead_cnt == DW'(DEAD_TICKS - 1)) begin
              state_d = at_tgt ? ST_IDLE : (want_up ? ST_UP : ST_DOWN);
              mov_d   = '0;
            end else begin
              dead_d = dead_cnt + DW'(1);
            end
          end
          ST_FAULT: if (stop_pend) state_d = ST_IDLE;
          default:  state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mov_cnt  <= '0;
      dead_cnt <= '0;
    end else begin
      state_q  <= state_d;
      mov_cnt  <= mov_d;
      dead_cnt <= dead_d;
    end
  end

  assign subir  = (state_q == ST_UP);
  assign bajar  = (state_q == ST_DOWN);
  assign fault  = (state_q == ST_FAULT);
  assign estado = state_q;

endmodule

// File: rtl/persiana_multicanal.sv
// N_CH independent blind controllers sharing a tick prescaler and light sensor.
// cmd_valid is a one-clk strobe with no ready: every legal command is taken on the edge it is shown.
module persiana_multicanal
  import persiana_pkg::*;
#(
  parameter int N_CH          = 2,
  parameter int DIV           = 25_000_000,
  parameter int TIMEOUT_TICKS = 16,
  parameter int DEAD_TICKS    = 2,
  localparam int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic [2:0]        cmd_mode,
  input  logic [1:0]        light,
  input  logic [N_CH-1:0]   s_inf,
  input  logic [N_CH-1:0]   s_med,
  input  logic [N_CH-1:0]   s_sup,
  output logic [N_CH-1:0]   subir,
  output logic [N_CH-1:0]   bajar,
  output logic [N_CH-1:0]   fault,
  output logic              tick,
  output logic [3*N_CH-1:0] estado_dbg
);

  localparam int PW = $clog2(DIV);

  logic [PW-1:0] pre_cnt;
  logic          cmd_legal;
  estado_t       estado_w [N_CH];

  // tick is registered, so it is raised one edge early to sit on count DIV-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      pre_cnt <= (pre_cnt == PW'(DIV - 1)) ? '0 : pre_cnt + PW'(1);
      tick    <= (pre_cnt == PW'(DIV - 2));
    end
  end

  assign cmd_legal = cmd_valid && (cmd_mode <= MODE_AUTO);

  for (genvar i = 0; i < N_CH; i++) begin : g_canal
    persiana_canal #(
      .TIMEOUT_TICKS (TIMEOUT_TICKS),
      .DEAD_TICKS    (DEAD_TICKS)
    ) u_canal (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .cmd_wr   (cmd_legal && (int'(cmd_ch) == i)),
      .cmd_mode (cmd_mode),
      .light    (light),
      .s_inf    (s_inf[i]),
      .s_med    (s_med[i]),
      .s_sup    (s_sup[i]),
      .subir    (subir[i]),
      .bajar    (bajar[i]),
      .fault    (fault[i]),
      .estado   (estado_w[i])
    );
    assign estado_dbg[3*i +: 3] = estado_w[i];
  end

endmodule

// File: tb/tb_persiana_multicanal.sv
// Directed bench for persiana_multicanal with DIV=4, TIMEOUT_TICKS=8, DEAD_TICKS=2, N_CH=2.
// Expected values are hand-derived per step; outputs are sampled 1ns after the active edge.
module tb_persiana_multicanal;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [0:0] cmd_ch;
  logic [2:0] cmd_mode;
  logic [1:0] light;
  logic [1:0] s_inf, s_med, s_sup;
  logic [1:0] subir, bajar, fault;
  logic       tick;
  logic [5:0] estado_dbg;

  int n_vec = 0;
  int n_err = 0;

  persiana_multicanal #(
    .N_CH          (2),
    .DIV           (4),
    .TIMEOUT_TICKS (8),
    .DEAD_TICKS    (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ch     (cmd_ch),
    .cmd_mode   (cmd_mode),
    .light      (light),
    .s_inf      (s_inf),
    .s_med      (s_med),
    .s_sup      (s_sup),
    .subir      (subir),
    .bajar      (bajar),
    .fault      (fault),
    .tick       (tick),
    .estado_dbg (estado_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    n_vec++;
    n_err++;
    $error("FAIL %s observed=timeout expected=tick", tag);
  endtask

  // Advance to just after the next clk edge on which tick is high.
  task automatic next_tick();
    int guard = 0;
    @(negedge clk);
    while (tick !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) bound_fail("next_tick");
    @(posedge clk);
    #1;
  endtask

  // Present one command for one clk; on_tick selects whether it lands on a tick edge.
  task automatic send_cmd(input logic [0:0] ch, input logic [2:0] mode, input bit on_tick);
    int guard = 0;
    @(negedge clk);
    while ((tick === 1'b1) != on_tick && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) bound_fail("send_cmd");
    cmd_valid = 1'b1;
    cmd_ch    = ch;
    cmd_mode  = mode;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    int ticks_seen;
    reset = 1'b1; cmd_valid = 1'b0; cmd_ch = '0; cmd_mode = '0;
    light = 2'b11; s_inf = '0; s_med = '0; s_sup = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_subir", 32'(subir), 32'h0);
    check("rst_bajar", 32'(bajar), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_estado", 32'(estado_dbg), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // ch0 open from unknown position, then reaches top
    send_cmd(1'b0, 3'b011, 1'b0);
    next_tick();
    check("open_up", 32'({subir, bajar, fault}), 32'({2'b01, 2'b00, 2'b00}));
    s_sup[0] = 1'b1;
    next_tick();
    check("open_top_stop", 32'({subir, bajar, fault}), 32'h0);

    // leave the top, then reverse with close
    s_sup[0] = 1'b0;
    next_tick();
    check("reopen_up", 32'({subir, bajar}), 32'({2'b01, 2'b00}));
    send_cmd(1'b0, 3'b001, 1'b0);
    next_tick();
    check("rev_dead_t0", 32'({subir, bajar}), 32'h0);
    check("rev_dead_state", 32'(estado_dbg[2:0]), 32'd3);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("rev_clk%0d", c), 32'({subir[0], bajar[0]}),
            (c == 8) ? 32'b01 : 32'b00);
    end
    s_inf[0] = 1'b1;
    next_tick();
    check("close_bot_stop", 32'({subir, bajar}), 32'h0);

    // ch1 close with no sensors: 8 ticks of motion then fault
    send_cmd(1'b1, 3'b001, 1'b0);
    for (int t = 0; t <= 8; t++) begin
      next_tick();
      check($sformatf("to_bajar_t%0d", t), 32'(bajar), (t < 8) ? 32'b10 : 32'b00);
      check($sformatf("to_fault_t%0d", t), 32'(fault), (t == 8) ? 32'b10 : 32'b00);
    end
    send_cmd(1'b1, 3'b011, 1'b0);
    next_tick();
    check("fault_open_ignored", 32'({fault, subir}), 32'({2'b10, 2'b00}));
    send_cmd(1'b1, 3'b000, 1'b0);
    next_tick();
    check("fault_stop_clears", 32'({fault, subir, bajar}), 32'h0);

    // ch0 auto from bottom: mid target goes up
    light = 2'b01;
    send_cmd(1'b0, 3'b100, 1'b0);
    next_tick();
    check("auto_mid_up", 32'({subir, bajar}), 32'({2'b01, 2'b00}));
    s_inf[0] = 1'b0;
    s_med[0] = 1'b1;
    next_tick();
    check("auto_mid_stop", 32'({subir, bajar}), 32'h0);
    light = 2'b11;
    next_tick();
    check("auto_hold", 32'({subir, bajar}), 32'h0);
    light = 2'b10;
    next_tick();
    check("auto_close_down", 32'({subir, bajar}), 32'({2'b00, 2'b01}));

    // contradictory end sensors while moving
    s_med[0] = 1'b0;
    s_inf[0] = 1'b1;
    s_sup[0] = 1'b1;
    next_tick();
    check("both_sens_fault", 32'({fault, bajar}), 32'({2'b01, 2'b00}));
    s_inf[0] = 1'b0;
    s_sup[0] = 1'b0;
    send_cmd(1'b0, 3'b000, 1'b0);
    next_tick();
    check("both_sens_clear", 32'(fault), 32'h0);

    // illegal code ignored, then reset mid-motion
    send_cmd(1'b1, 3'b001, 1'b0);
    next_tick();
    check("ch1_down", 32'({subir, bajar}), 32'({2'b00, 2'b10}));
    send_cmd(1'b1, 3'b111, 1'b0);
    next_tick();
    check("illegal_ignored", 32'({subir, bajar}), 32'({2'b00, 2'b10}));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_outs", 32'({subir, bajar, fault}), 32'h0);
    check("rst_mid_tick", 32'(tick), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // command coincident with a tick: old mode used on that tick
    send_cmd(1'b1, 3'b011, 1'b0);
    send_cmd(1'b1, 3'b001, 1'b1);
    check("coinc_old_mode", 32'({subir, bajar}), 32'({2'b10, 2'b00}));
    next_tick();
    check("coinc_dead1", 32'({subir, bajar}), 32'h0);
    next_tick();
    check("coinc_dead2", 32'({subir, bajar}), 32'h0);
    next_tick();
    check("coinc_new_mode", 32'({subir, bajar}), 32'({2'b00, 2'b10}));

    // prescaler: one tick per four clocks
    ticks_seen = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (tick === 1'b1) ticks_seen++;
    end
    check("tick_rate", 32'(ticks_seen), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
